// File: rtl/invert_sq_root.sv
// invert_sq_root: fully pipelined binary32 reciprocal square root (magic-constant seed + Newton step).
// Optional macro INVSQRT_SECOND_ITER_EN appends a second Newton step (latency 9 instead of 5).
module invert_sq_root #(
  parameter logic [31:0] MAGIC = 32'h5F3759DF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut
);
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] F_INF  = 32'h7F800000;
  localparam logic [DATA_W-1:0] F_QNAN = 32'h7FC00000;
  // 1.5 in unsigned Q2.26
  localparam logic [27:0] ONE_P5 = 28'h600_0000;

  typedef enum logic [1:0] {SC_NORM = 2'd0, SC_INF = 2'd1, SC_ZERO = 2'd2, SC_NAN = 2'd3} sc_e;

  function automatic sc_e classify(input logic [DATA_W-1:0] x);
    if (x[30:23] == 8'd0)                          classify = SC_INF;
    else if (x[30:23] == 8'hFF && x[22:0] != '0)   classify = SC_NAN;
    else if (x[31])                                classify = SC_NAN;
    else if (x[30:23] == 8'hFF)                    classify = SC_ZERO;
    else                                           classify = SC_NORM;
  endfunction

  function automatic logic [DATA_W-1:0] halve(input logic [DATA_W-1:0] x);
    if (x[30:23] == 8'd0) halve = '0;
    else                  halve = {x[31], x[30:23] - 8'd1, x[22:0]};
  endfunction

  // Positive-only multiply: truncated 24x24 mantissa product, flush-to-zero on underflow.
  function automatic logic [DATA_W-1:0] fmul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [47:0]       prod;
    logic signed [9:0] e;
    logic [22:0]       m;
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      m = prod[46:24];
      e = e + 10'sd1;
    end else begin
      m = prod[45:23];
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0) fmul = '0;
    else if (e >= 10'sd255)                                   fmul = F_INF;
    else                                                      fmul = {1'b0, e[7:0], m};
  endfunction

  // 1.5 - t by aligning t into Q2.26 and renormalising the difference.
  function automatic logic [DATA_W-1:0] sub_from_1p5(input logic [DATA_W-1:0] t);
    logic [27:0] tf;
    logic [27:0] diff;
    logic [27:0] norm;
    logic [7:0]  sh;
    int          msb;
    sub_from_1p5 = '0;
    tf   = '0;
    sh   = '0;
    msb  = 0;
    diff = '0;
    norm = '0;
    if (t[30:23] > 8'd127) begin
      tf = ONE_P5;
    end else if (t[30:23] != 8'd0) begin
      sh = 8'd127 - t[30:23];
      tf = {2'b01, t[22:0], 3'b000} >> sh;
    end
    if (tf < ONE_P5) begin
      diff = ONE_P5 - tf;
      for (int i = 0; i < 28; i++) if (diff[i]) msb = i;
      norm = diff << (27 - msb);
      sub_from_1p5 = {1'b0, 8'(msb + 101), norm[26:4]};
    end
  endfunction

  function automatic logic [DATA_W-1:0] finish(input logic vld, input sc_e code, input logic [DATA_W-1:0] y);
    if (!vld) finish = '0;
    else begin
      case (code)
        SC_INF:  finish = F_INF;
        SC_ZERO: finish = '0;
        SC_NAN:  finish = F_QNAN;
        default: finish = y;
      endcase
    end
  endfunction

  logic              vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic              vld_p3_q, vld_p3_d, vld_p4_q, vld_p4_d;
  sc_e               code_p1_q, code_p1_d, code_p2_q, code_p2_d, code_p3_q, code_p3_d, code_p4_q, code_p4_d;
  logic [DATA_W-1:0] x_p0_q, x_p0_d;
  logic [DATA_W-1:0] y0_p1_q, y0_p1_d, y0_p2_q, y0_p2_d, y0_p3_q, y0_p3_d, y0_p4_q, y0_p4_d;
  logic [DATA_W-1:0] h_p1_q, h_p1_d, h_p2_q, h_p2_d;
  logic [DATA_W-1:0] t1_p2_q, t1_p2_d, t2_p3_q, t2_p3_d, t3_p4_q, t3_p4_d;
  logic [DATA_W-1:0] out_q, out_d;
`ifdef INVSQRT_SECOND_ITER_EN
  logic              vld_p5_q, vld_p5_d, vld_p6_q, vld_p6_d, vld_p7_q, vld_p7_d, vld_p8_q, vld_p8_d;
  sc_e               code_p5_q, code_p5_d, code_p6_q, code_p6_d, code_p7_q, code_p7_d, code_p8_q, code_p8_d;
  logic [DATA_W-1:0] h_p3_q, h_p3_d, h_p4_q, h_p4_d, h_p5_q, h_p5_d, h_p6_q, h_p6_d;
  logic [DATA_W-1:0] y1_p5_q, y1_p5_d, y1_p6_q, y1_p6_d, y1_p7_q, y1_p7_d, y1_p8_q, y1_p8_d;
  logic [DATA_W-1:0] t1_p6_q, t1_p6_d, t2_p7_q, t2_p7_d, t3_p8_q, t3_p8_d;
`endif

  always_comb begin
    // p0: operand capture
    vld_p0_d  = 1'b1;
    x_p0_d    = DataIn;
    // p1: seed, half operand, special-case code
    vld_p1_d  = vld_p0_q;
    code_p1_d = classify(x_p0_q);
    y0_p1_d   = MAGIC - {1'b0, x_p0_q[31:1]};
    h_p1_d    = halve(x_p0_q);
    // p2: y0*y0
    vld_p2_d  = vld_p1_q;
    code_p2_d = code_p1_q;
    y0_p2_d   = y0_p1_q;
    h_p2_d    = h_p1_q;
    t1_p2_d   = fmul(y0_p1_q, y0_p1_q);
    // p3: h*t1
    vld_p3_d  = vld_p2_q;
    code_p3_d = code_p2_q;
    y0_p3_d   = y0_p2_q;
    t2_p3_d   = fmul(h_p2_q, t1_p2_q);
    // p4: 1.5 - t2
    vld_p4_d  = vld_p3_q;
    code_p4_d = code_p3_q;
    y0_p4_d   = y0_p3_q;
    t3_p4_d   = sub_from_1p5(t2_p3_q);
`ifdef INVSQRT_SECOND_ITER_EN
    h_p3_d    = h_p2_q;
    h_p4_d    = h_p3_q;
    // p5: first refinement y1
    vld_p5_d  = vld_p4_q;
    code_p5_d = code_p4_q;
    h_p5_d    = h_p4_q;
    y1_p5_d   = fmul(y0_p4_q, t3_p4_q);
    // p6..p8: second Newton step on y1
    vld_p6_d  = vld_p5_q;
    code_p6_d = code_p5_q;
    h_p6_d    = h_p5_q;
    y1_p6_d   = y1_p5_q;
    t1_p6_d   = fmul(y1_p5_q, y1_p5_q);
    vld_p7_d  = vld_p6_q;
    code_p7_d = code_p6_q;
    y1_p7_d   = y1_p6_q;
    t2_p7_d   = fmul(h_p6_q, t1_p6_q);
    vld_p8_d  = vld_p7_q;
    code_p8_d = code_p7_q;
    y1_p8_d   = y1_p7_q;
    t3_p8_d   = sub_from_1p5(t2_p7_q);
    out_d     = finish(vld_p8_q, code_p8_q, fmul(y1_p8_q, t3_p8_q));
`else
    out_d     = finish(vld_p4_q, code_p4_q, fmul(y0_p4_q, t3_p4_q));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0; vld_p1_q <= 1'b0; vld_p2_q <= 1'b0; vld_p3_q <= 1'b0; vld_p4_q <= 1'b0;
      code_p1_q <= SC_NORM; code_p2_q <= SC_NORM; code_p3_q <= SC_NORM; code_p4_q <= SC_NORM;
      x_p0_q <= '0; y0_p1_q <= '0; y0_p2_q <= '0; y0_p3_q <= '0; y0_p4_q <= '0;
      h_p1_q <= '0; h_p2_q <= '0; t1_p2_q <= '0; t2_p3_q <= '0; t3_p4_q <= '0;
      out_q <= '0;
`ifdef INVSQRT_SECOND_ITER_EN
      vld_p5_q <= 1'b0; vld_p6_q <= 1'b0; vld_p7_q <= 1'b0; vld_p8_q <= 1'b0;
      code_p5_q <= SC_NORM; code_p6_q <= SC_NORM; code_p7_q <= SC_NORM; code_p8_q <= SC_NORM;
      h_p3_q <= '0; h_p4_q <= '0; h_p5_q <= '0; h_p6_q <= '0;
      y1_p5_q <= '0; y1_p6_q <= '0; y1_p7_q <= '0; y1_p8_q <= '0;
      t1_p6_q <= '0; t2_p7_q <= '0; t3_p8_q <= '0;
`endif
    end else begin
      vld_p0_q <= vld_p0_d; vld_p1_q <= vld_p1_d; vld_p2_q <= vld_p2_d; vld_p3_q <= vld_p3_d; vld_p4_q <= vld_p4_d;
      code_p1_q <= code_p1_d; code_p2_q <= code_p2_d; code_p3_q <= code_p3_d; code_p4_q <= code_p4_d;
      x_p0_q <= x_p0_d; y0_p1_q <= y0_p1_d; y0_p2_q <= y0_p2_d; y0_p3_q <= y0_p3_d; y0_p4_q <= y0_p4_d;
      h_p1_q <= h_p1_d; h_p2_q <= h_p2_d; t1_p2_q <= t1_p2_d; t2_p3_q <= t2_p3_d; t3_p4_q <= t3_p4_d;
      out_q <= out_d;
`ifdef INVSQRT_SECOND_ITER_EN
      vld_p5_q <= vld_p5_d; vld_p6_q <= vld_p6_d; vld_p7_q <= vld_p7_d; vld_p8_q <= vld_p8_d;
      code_p5_q <= code_p5_d; code_p6_q <= code_p6_d; code_p7_q <= code_p7_d; code_p8_q <= code_p8_d;
      h_p3_q <= h_p3_d; h_p4_q <= h_p4_d; h_p5_q <= h_p5_d; h_p6_q <= h_p6_d;
      y1_p5_q <= y1_p5_d; y1_p6_q <= y1_p6_d; y1_p7_q <= y1_p7_d; y1_p8_q <= y1_p8_d;
      t1_p6_q <= t1_p6_d; t2_p7_q <= t2_p7_d; t3_p8_q <= t3_p8_d;
`endif
    end
  end

  assign DataOut = out_q;

endmodule

// File: tb/tb_invert_sq_root.sv
// Directed testbench for invert_sq_root; define INVSQRT_SECOND_ITER_EN to check the two-step build.
module tb_invert_sq_root;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  int          total = 0;
  int          bad   = 0;

`ifdef INVSQRT_SECOND_ITER_EN
  localparam int  LAT = 9;
  localparam real TOL = 1.0e-5;
`else
  localparam int  LAT = 5;
  localparam real TOL = 2.0e-3;
`endif

  invert_sq_root dut (
    .clk    (clk),
    .rst    (rst),
    .DataIn (DataIn),
    .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Magnitude of a normal binary32 pattern as a real (0 for exponent 0).
  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    v = 1.0 + $itor({9'd0, b[22:0]}) / 8388608.0;
    e = {24'd0, b[30:23]};
    if (e == 0) return 0.0;
    for (int k = e; k > 127; k--) v = v * 2.0;
    for (int k = e; k < 127; k++) v = v / 2.0;
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] want);
    total++;
    assert (DataOut === want)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, DataOut, want);
    end
  endtask

  task automatic check_near(input string tag, input real want);
    real  got;
    real  rel;
    logic ok;
    got = f2r(DataOut);
    rel = (got - want) / want;
    if (rel < 0.0) rel = -rel;
    ok = (DataOut[31] == 1'b0) && (DataOut[30:23] != 8'd0) && (DataOut[30:23] != 8'hFF) && (rel <= TOL);
    total++;
    assert (ok === 1'b1)
    else begin
      bad++;
      $error("FAIL %s: got %h (%f) expected %f rel_err %e", tag, DataOut, got, want, rel);
    end
  endtask

  logic [31:0] stream_in   [5] = '{32'h3DCCCCCD, 32'h3F000000, 32'h3F800000, 32'h40800000, 32'h42C80000};
  real         stream_want [5] = '{3.16227766, 1.41421356, 1.0, 0.5, 0.1};
  logic [31:0] spec_in     [7] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hBF800000,
                                   32'h7FC00001, 32'h00000001, 32'hFF800000};
  logic [31:0] spec_want   [7] = '{32'h7F800000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                                   32'h7FC00000, 32'h7F800000, 32'h7FC00000};

  initial begin
    rst    = 1'b1;
    DataIn = 32'h3F800000;
    step(2);
    check_eq("reset_out", 32'h0);

    // 1.0 is sampled on the first edge after rst drops
    rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      step(1);
      check_eq("pre_latency", 32'h0);
    end
    step(1);
    check_near("one", 1.0);

    DataIn = 32'h3DCCCCCD;
    step(200);
    check_near("tenth_held", 3.16227766);

    DataIn = 32'h3F000000;
    step(LAT + 1);
    check_near("half", 1.41421356);

    for (int j = 0; j < 5 + LAT; j++) begin
      if (j < 5) DataIn = stream_in[j];
      step(1);
      if (j >= LAT) check_near($sformatf("stream%0d", j - LAT), stream_want[j - LAT]);
    end

    for (int s = 0; s < 7; s++) begin
      DataIn = spec_in[s];
      step(LAT + 1);
      check_eq($sformatf("special_%h", spec_in[s]), spec_want[s]);
    end

    // three operands in flight, then a one-cycle reset
    DataIn = 32'h40800000;
    step(1);
    DataIn = 32'h3F800000;
    step(1);
    DataIn = 32'h3DCCCCCD;
    step(1);
    rst = 1'b1;
    step(1);
    check_eq("rst_flush", 32'h0);
    rst    = 1'b0;
    DataIn = 32'h3F000000;
    for (int i = 0; i < LAT; i++) begin
      step(1);
      check_eq("flushed_stays_zero", 32'h0);
    end
    step(1);
    check_near("after_rst", 1.41421356);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
